mandelbrot_pixel_write_arbiter: RTL and testbench

//  Collects finished pixels from NUM_ITERATORS Mandelbrot iterators and shares the single
//  VGA SRAM write port between them: round-robin grant, result capture, colour mapping and

---
 rtl/mandelbrot_pixel_write_arbiter_if.sv | 11 +
 rtl/mandelbrot_pixel_write_arbiter.sv | 110 +++++++++++
 tb/tb_mandelbrot_pixel_write_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mandelbrot_pixel_write_arbiter_if.sv
// mandelbrot_pixel_write_arbiter_if: SRAM write-port bus between the pixel arbiter and the SRAM master.
interface mandelbrot_pixel_write_arbiter_if #(
    parameter int ADDR_WIDTH = 19
);
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_data;
    logic                  wr_ack;
    modport master(output wr_req, wr_addr, wr_data, input wr_ack);
    modport slave(input wr_req, wr_addr, wr_data, output wr_ack);
endinterface

// File: rtl/mandelbrot_pixel_write_arbiter.sv
// mandelbrot_pixel_write_arbiter: round-robin share of the SRAM write port among iterators, with colour map and address gen.
// Optional stall counter enabled by defining MANDEL_WRITE_STALL_COUNT_EN.
module mandelbrot_pixel_write_arbiter #(
    parameter int NUM_ITERATORS = 25,
    parameter int ITER_WIDTH    = 11,
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 10,
    parameter int ADDR_WIDTH    = 19,
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_ITERATORS-1:0]           iter_done,
    input  logic [NUM_ITERATORS*ITER_WIDTH-1:0] iter_num_iter,
    input  logic [NUM_ITERATORS*X_WIDTH-1:0]   iter_x,
    input  logic [NUM_ITERATORS*Y_WIDTH-1:0]   iter_y,
    output logic [NUM_ITERATORS-1:0]           iter_ack,
    input  logic [31:0]                        max_iter,
    mandelbrot_pixel_write_arbiter_if.master   wr,
    input  logic                               frame_start,
    output logic                               frame_done,
    output logic [31:0]                        pixels_written,
    output logic [31:0]                        stall_cycles
);
    localparam int PW = NUM_ITERATORS > 1 ? $clog2(NUM_ITERATORS) : 1;
    localparam logic [31:0] LAST = 32'(SCREEN_W * SCREEN_H - 1);
    typedef enum logic {IDLE, WRITE} state_t;
    state_t                state;
    logic [PW-1:0]         rr_ptr, cur, win, idx;
    logic                  any, done_edge;
    int                    j;
    logic [ITER_WIDTH-1:0] sel_n;
    logic [X_WIDTH-1:0]    sel_x;
    logic [Y_WIDTH-1:0]    sel_y;
    logic [31:0]           n32, addr_full;
    logic [7:0]            colour;
    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        j = 0;
        for (int i = NUM_ITERATORS - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            idx = PW'(j >= NUM_ITERATORS ? j - NUM_ITERATORS : j);
            if (iter_done[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end
    assign sel_n = iter_num_iter[int'(win)*ITER_WIDTH +: ITER_WIDTH];
    assign sel_x = iter_x[int'(win)*X_WIDTH +: X_WIDTH];
    assign sel_y = iter_y[int'(win)*Y_WIDTH +: Y_WIDTH];
    assign n32 = 32'(sel_n);
    assign addr_full = 32'(sel_y) * 32'(SCREEN_W) + 32'(sel_x);
    assign colour = n32 >= max_iter        ? 8'h00 :
                    n32 >= (max_iter >> 1) ? 8'hFF :
                    n32 >= (max_iter >> 2) ? 8'hFC :
                    n32 >= (max_iter >> 3) ? 8'hE0 :
                    n32 >= (max_iter >> 4) ? 8'h1F : 8'h03;
    assign done_edge = state == WRITE && wr.wr_ack;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            cur            <= '0;
            iter_ack       <= '0;
            wr.wr_req      <= 1'b0;
            wr.wr_addr     <= '0;
            wr.wr_data     <= '0;
            frame_done     <= 1'b0;
            pixels_written <= '0;
        end else begin
            iter_ack <= '0;
            if (state == IDLE) begin
                if (any) begin
                    iter_ack[win] <= 1'b1;
                    cur           <= win;
                    wr.wr_req     <= 1'b1;
                    wr.wr_addr    <= ADDR_WIDTH'(addr_full);
                    wr.wr_data    <= colour;
                    state         <= WRITE;
                end
            end else if (wr.wr_ack) begin
                wr.wr_req <= 1'b0;
                rr_ptr    <= cur == PW'(NUM_ITERATORS - 1) ? '0 : cur + 1'b1;
                state     <= IDLE;
            end
            // A completion coincident with frame_start belongs to neither frame's count.
            if (frame_start) begin
                pixels_written <= '0;
                frame_done     <= 1'b0;
            end else if (done_edge) begin
                pixels_written <= pixels_written == '1 ? pixels_written : pixels_written + 1'b1;
                if (pixels_written == LAST) frame_done <= 1'b1;
            end
        end
    end
`ifdef MANDEL_WRITE_STALL_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cycles <= '0;
        else if (frame_start) stall_cycles <= '0;
        else if (state == WRITE && !wr.wr_ack && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
    end
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_mandelbrot_pixel_write_arbiter.sv
// tb_mandelbrot_pixel_write_arbiter: directed checks of grant order, colour map, addressing, stall and frame counting.
module tb_mandelbrot_pixel_write_arbiter;
    localparam int N = 25, IW = 11, XW = 10, YW = 10, AW = 19;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  iter_done = '0, iter_ack;
    logic [N*IW-1:0] iter_num_iter = '0;
    logic [N*XW-1:0] iter_x = '0;
    logic [N*YW-1:0] iter_y = '0;
    logic [31:0]   max_iter = 32'd1000, pixels_written, stall_cycles;
    logic          frame_start = 1'b0, frame_done;
    int            checks = 0, errors = 0;
    int            t_max[10], t_n[10], t_c[10];
    logic [31:0]   stall_exp;
    always #5 clk = ~clk;
    mandelbrot_pixel_write_arbiter_if #(.ADDR_WIDTH(AW)) bus();
    mandelbrot_pixel_write_arbiter #(
        .NUM_ITERATORS(N), .ITER_WIDTH(IW), .X_WIDTH(XW), .Y_WIDTH(YW),
        .ADDR_WIDTH(AW), .SCREEN_W(4), .SCREEN_H(2)
    ) dut (
        .clk(clk), .reset(reset), .iter_done(iter_done), .iter_num_iter(iter_num_iter),
        .iter_x(iter_x), .iter_y(iter_y), .iter_ack(iter_ack), .max_iter(max_iter),
        .wr(bus), .frame_start(frame_start), .frame_done(frame_done),
        .pixels_written(pixels_written), .stall_cycles(stall_cycles)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic set_it(input int k, input int n, input int x, input int y);
        iter_num_iter[k*IW +: IW] = IW'(n);
        iter_x[k*XW +: XW] = XW'(x);
        iter_y[k*YW +: YW] = YW'(y);
    endtask
    initial begin
        t_max = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 0, 3};
        t_n   = '{999, 499, 250, 249, 125, 124, 62, 61, 0, 0};
        t_c   = '{'hFF, 'hFC, 'hFC, 'hE0, 'hE0, 'h1F, 'h1F, 'h03, 'h00, 'hFC};
        bus.wr_ack = 1'b0;
`ifdef MANDEL_WRITE_STALL_COUNT_EN
        stall_exp = 32'd7;
`else
        stall_exp = 32'd0;
`endif
        step(); step();
        chk("rst_req", {31'b0, bus.wr_req}, 0);
        chk("rst_ack", iter_ack, 0);
        chk("rst_addr", bus.wr_addr, 0);
        chk("rst_data", bus.wr_data, 0);
        chk("rst_fd", {31'b0, frame_done}, 0);
        chk("rst_pix", pixels_written, 0);
        chk("rst_stall", stall_cycles, 0);
        reset = 1'b0;
        // single request from iterator 3
        set_it(3, 5, 2, 1);
        iter_done[3] = 1'b1;
        bus.wr_ack = 1'b1;
        step();
        chk("t1_ack", iter_ack, 32'h8);
        chk("t1_req", {31'b0, bus.wr_req}, 1);
        chk("t1_addr", bus.wr_addr, 6);
        chk("t1_data", bus.wr_data, 8'h03);
        iter_done[3] = 1'b0;
        step();
        chk("t1_ack_off", iter_ack, 0);
        chk("t1_req_off", {31'b0, bus.wr_req}, 0);
        chk("t1_pix", pixels_written, 1);
        // reset during a write
        set_it(10, 0, 0, 0);
        iter_done[10] = 1'b1;
        bus.wr_ack = 1'b0;
        step();
        chk("t6_req", {31'b0, bus.wr_req}, 1);
        chk("t6_ack", iter_ack, 32'h400);
        #2 reset = 1'b1;
        #1;
        chk("t6_req_async", {31'b0, bus.wr_req}, 0);
        chk("t6_pix_async", pixels_written, 0);
        iter_done = '0;
        step();
        reset = 1'b0;
        // all iterators requesting at once
        for (int k = 0; k < N; k++) set_it(k, k, k, 0);
        iter_done = '1;
        bus.wr_ack = 1'b1;
        for (int i = 0; i < N; i++) begin
            step();
            chk($sformatf("t2_ack%0d", i), iter_ack, 32'(1) << i);
            chk($sformatf("t2_addr%0d", i), bus.wr_addr, i);
            iter_done[i] = 1'b0;
            step();
            chk($sformatf("t2_gap%0d", i), {31'b0, bus.wr_req}, 0);
        end
        chk("t2_pix", pixels_written, 25);
        chk("t2_fd", {31'b0, frame_done}, 1);
        // frame_start clears, then a stalled write
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("fs_pix", pixels_written, 0);
        chk("fs_fd", {31'b0, frame_done}, 0);
        set_it(7, 1000, 3, 1);
        iter_done[7] = 1'b1;
        bus.wr_ack = 1'b0;
        step();
        chk("t3_ack", iter_ack, 32'h80);
        iter_done[7] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t3_req", {31'b0, bus.wr_req}, 1);
            chk("t3_addr", bus.wr_addr, 7);
            chk("t3_data", bus.wr_data, 8'h00);
        end
        bus.wr_ack = 1'b1;
        step();
        chk("t3_stall", stall_cycles, stall_exp);
        chk("t3_pix", pixels_written, 1);
        chk("t3_req_off", {31'b0, bus.wr_req}, 0);
        // two requests with wrap-around from rr_ptr=8
        set_it(20, 1000, 0, 0);
        set_it(2, 600, 1, 0);
        iter_done[20] = 1'b1;
        iter_done[2] = 1'b1;
        step();
        chk("t4_ack20", iter_ack, 32'h100000);
        chk("t4_data20", bus.wr_data, 8'h00);
        iter_done[20] = 1'b0;
        step();
        step();
        chk("t4_ack2", iter_ack, 32'h4);
        chk("t4_data2", bus.wr_data, 8'hFF);
        iter_done[2] = 1'b0;
        step();
        // colour band boundaries
        for (int i = 0; i < 10; i++) begin
            max_iter = t_max[i];
            set_it(i, t_n[i], i % 4, i / 4);
            iter_done[i] = 1'b1;
            step();
            chk($sformatf("col%0d", i), bus.wr_data, t_c[i]);
            chk($sformatf("addr%0d", i), bus.wr_addr, i);
            iter_done[i] = 1'b0;
            step();
        end
        chk("col_pix", pixels_written, 13);
        max_iter = 32'd1000;
        // full 4x2 frame
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t5_pix0", pixels_written, 0);
        chk("t5_fd0", {31'b0, frame_done}, 0);
        for (int i = 0; i < 8; i++) begin
            set_it(0, 5, i % 4, i / 4);
            iter_done[0] = 1'b1;
            step();
            chk($sformatf("t5_addr%0d", i), bus.wr_addr, i);
            iter_done[0] = 1'b0;
            step();
            chk($sformatf("t5_pix%0d", i), pixels_written, i + 1);
            chk($sformatf("t5_fd%0d", i), {31'b0, frame_done}, (i == 7) ? 1 : 0);
        end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t5_clr_pix", pixels_written, 0);
        chk("t5_clr_fd", {31'b0, frame_done}, 0);
        // completion coincident with frame_start is not counted
        iter_done[0] = 1'b1;
        step();
        iter_done[0] = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("co_pix", pixels_written, 0);
        chk("co_req", {31'b0, bus.wr_req}, 0);
        step();
        chk("co_pix_after", pixels_written, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
